dmem_arbiter: RTL
=================

# dmem_arbiter

Two-master arbiter that shares the single-port data RAM between the CPU load/store path (master 0) and a secondary bus master such as a UART loader or DMA engine (master 1). It sits between the memory manager's RAM-side outputs and `data_memory`. Each cycle it grants at most one master, multiplexes that master's request onto the RAM port, and routes the one-cycle-late read data back to the correct requester. The CPU stalls whenever `m0_gnt` is low while `m0_req` is high.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 8: consecutive denied cycles of master 1 before a forced grant. Only used with the starvation guard; legal range 1..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` input 1 each: access request, held until granted.
- `m0_we`, `m1_we` input 1 each: 1 = write, 0 = read.
- `m0_lock`, `m1_lock` input 1 each: keep ownership on the next cycle. Sampled only in a granted cycle.
- `m0_addr`, `m1_addr` input ADDR_W each: byte address.
- `m0_wdata`, `m1_wdata` input DATA_W each: write data.
- `m0_gnt`, `m1_gnt` output 1 each: the request is accepted this cycle.
- `m0_rvalid`, `m1_rvalid` output 1 each: read data valid; one-cycle pulse.
- `m0_rdata`, `m1_rdata` output DATA_W each: read data, qualified by rvalid.
- `ram_en`, `ram_we` output 1 each: RAM enable and write enable.
- `ram_addr` output ADDR_W: RAM address.
- `ram_wdata` output DATA_W: RAM write data.
- `ram_rdata` input DATA_W: RAM read data, valid one cycle after `ram_en`.

## Operation
FSM states:
- IDLE: no owner.
- OWN0: master 0 holds a lock.
- OWN1: master 1 holds a lock.

Arbitration, evaluated combinationally each cycle, in priority order:
1. Starvation guard fires (configured in and counter == STARVE_LIMIT) and `m1_req`: grant master 1. This overrides a lock held by master 0.
2. State OWN0 and `m0_req`: grant master 0. State OWN1 and `m1_req`: grant master 1.
3. `m0_req`: grant master 0.
4. `m1_req`: grant master 1.
5. Otherwise no grant.

Request path:
- Granted master's `we`, `addr` and `wdata` drive the RAM port; `ram_en` = any grant.
- With no grant: `ram_en` = 0, `ram_we` = 0, and addr/wdata = 0.

Next state at each edge:
- Granted master x with `mx_lock` = 1: go to OWNx.
- Any other case (no grant, or granted without lock): go to IDLE.
- An owner that drops `req` releases the lock; the state returns to IDLE.

Read return:
- A 2-bit register records which master had a granted read.
- Next cycle, that master's `rvalid` = 1 and its `rdata` = `ram_rdata`.
- The non-selected `rdata` output is driven to 0.
- Writes produce no rvalid; a write completes at the grant edge.

Invariants:
- `m0_gnt` and `m1_gnt` are never both high.
- At most one rvalid is high in any cycle.

## Timing
- Grant is combinational: `req` in cycle N gives `gnt` and `ram_en` in cycle N.
- Read data returns in cycle N+1 with rvalid.
- Back-to-back grants are allowed every cycle, including alternating masters. Read returns stay ordered and are never lost.
- A simultaneous request from both masters in IDLE resolves to master 0, unless the guard fires.
- Reset asserted, asynchronously:
  - state = IDLE, read-return register = 0, starvation counter = 0.
  - `m0_gnt`, `m1_gnt`, `ram_en` and `ram_we` are forced to 0 while reset is low.
  - all rvalid outputs = 0; rdata, ram_addr and ram_wdata = 0.
- Reset mid-operation: a read granted in the cycle before reset produces no rvalid after release.
- First grant possible in the first cycle with `rst` high.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - An 8-bit counter increments each cycle that `m1_req` is high and `m1_gnt` is low.
  - The counter saturates at STARVE_LIMIT and clears on `m1_gnt` or when `m1_req` is low.
  - When the counter == STARVE_LIMIT, master 1 wins the next arbitration, as in rule 1.
- Not defined: the counter is absent and master 0 has strict priority, so master 1 can starve indefinitely.

## Test plan
- Reset: hold `rst` = 0 with both requests high → no gnt, `ram_en` = 0, no rvalid. Release → `m0_gnt` = 1 in the first cycle.
- Read routing:
  - Master 1 alone reads 0x40, with RAM preloaded 0xDEADBEEF → `m1_gnt` in cycle N.
  - In cycle N+1: `m1_rvalid` = 1, `m1_rdata` = 0xDEADBEEF, and `m0_rvalid` = 0.
- Alternating traffic: master 0 writes 0x10 ← 0x1234, then master 1 reads 0x10 in the next cycle → `m1_rdata` = 0x1234 at N+2.
- Lock:
  - Master 1 is granted with `m1_lock` = 1, then both masters request for 3 cycles → master 1 is granted all 3 cycles.
  - Master 1 drops the lock → master 0 is granted the next cycle.
- Starvation, with the macro defined and STARVE_LIMIT = 4: both masters request continuously → master 0 is granted for 4 cycles, then master 1 once, repeating. Without the macro, master 1 is never granted.
- Mid-read reset: master 0 read granted in cycle N, `rst` pulsed low in cycle N+1 → `m0_rvalid` stays 0 and the state is IDLE afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of the single-port data RAM.
// Optional starvation guard for master 1: DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_rd_sel;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_starve;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT out of range 1..255");
  end

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] r_starve_cnt;

  // Count consecutive denied cycles of master 1, saturating at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= 8'd0;
    end else if (w_gnt1 || !m1_req) begin
      r_starve_cnt <= 8'd0;
    end else if (r_starve_cnt < LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  assign w_starve = (r_starve_cnt == LP_LIMIT);
`else
  assign w_starve = 1'b0;
`endif

  // Ownership state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration and next state; no grant while reset is held low
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = IDLE;
    if (rst) begin
      if (w_starve && m1_req) begin
        w_gnt1 = 1'b1;
      end else if (r_state == OWN0 && m0_req) begin
        w_gnt0 = 1'b1;
      end else if (r_state == OWN1 && m1_req) begin
        w_gnt1 = 1'b1;
      end else if (m0_req) begin
        w_gnt0 = 1'b1;
      end else if (m1_req) begin
        w_gnt1 = 1'b1;
      end
    end
    if (w_gnt0 && m0_lock) begin
      w_state_nxt = OWN0;
    end else if (w_gnt1 && m1_lock) begin
      w_state_nxt = OWN1;
    end
  end

  // Steer the granted master's request onto the RAM port
  always_comb begin
    ram_en    = w_gnt0 | w_gnt1;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (w_gnt0) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (w_gnt1) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
  end

  // Remember which master owns the read data arriving next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_sel <= 2'b00;
    end else begin
      r_rd_sel <= {w_gnt1 & ~m1_we, w_gnt0 & ~m0_we};
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_rd_sel[0];
  assign m1_rvalid = r_rd_sel[1];
  assign m0_rdata  = r_rd_sel[0] ? ram_rdata : '0;
  assign m1_rdata  = r_rd_sel[1] ? ram_rdata : '0;

endmodule
